// File: rtl/dd_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : dd_pkg
//  Description : Constants and helpers shared by the FX3 sample-buffer path.
//  Revision    : 1.0  initial release
// ============================================================================
package dd_pkg;

    localparam int FX3_PACKET_WORDS = 8192;   // words per FX3 packet
    localparam int ADC_W            = 10;     // ADC sample width
    localparam int FX3_BUS_W        = 16;     // GPIF data bus width

    // A fill level has to hold every value 0..depth inclusive, hence the +1.
    function automatic int fillLevelWidth(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sync_fifo_fwft.sv
`default_nettype none
// ============================================================================
//  Module      : sync_fifo_fwft
//  Description : Single-clock show-ahead FIFO built on a registered-read
//                dual-port RAM. The head word sits on o_rdData before it is
//                popped; a word written into an empty FIFO is presented two
//                edges after its write edge. o_rdData is zero while no head
//                word is presentable.
//  Revision    : 1.0  initial release
// ============================================================================
module sync_fifo_fwft
    import dd_pkg::*;
#(
    parameter  int DEPTH = 16384,
    parameter  int WIDTH = ADC_W,
    localparam int AW    = $clog2(DEPTH),
    localparam int LW    = fillLevelWidth(DEPTH)
) (
    input  logic             inclk,
    input  logic             nReset,
    input  logic             i_wrReq,
    input  logic [WIDTH-1:0] i_wrData,
    input  logic             i_rdReq,
    output logic [WIDTH-1:0] o_rdData,
    output logic [LW-1:0]    o_level,
    output logic [LW-1:0]    o_levelNext,
    output logic             o_wrDropped,
    output logic             o_rdWhileEmpty
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [WIDTH-1:0] r_ramQ;
    logic [AW-1:0]    r_wrPtr;
    logic [AW-1:0]    r_rdPtr;
    logic [AW-1:0]    w_rdPtrNext;
    logic [LW-1:0]    r_level;
    logic [LW-1:0]    w_levelNext;
    logic             r_headValid;
    logic             r_headFresh;
    logic             w_empty;
    logic             w_full;
    logic             w_pop;
    logic             w_push;
    logic             w_headNew;

    assign w_empty = (r_level == '0);
    assign w_full  = (r_level == LW'(DEPTH));
    assign w_pop   = i_rdReq && !w_empty;
    // When full, a write only fits if a pop frees a slot on the same edge.
    assign w_push  = i_wrReq && (!w_full || w_pop);

    // The RAM is addressed with the post-pop read pointer so the registered
    // read lands on the new head one edge later with no bubble.
    assign w_rdPtrNext = w_pop ? (r_rdPtr + AW'(1)) : r_rdPtr;

    // After this edge the head is the word being written now; the RAM read
    // on this same edge still returns the old contents of that address.
    assign w_headNew = w_push && (w_levelNext == LW'(1));

    // Next fill level from the accepted push/pop pair.
    always_comb begin
        w_levelNext = r_level;
        case ({w_push, w_pop})
            2'b10:   w_levelNext = r_level + LW'(1);
            2'b01:   w_levelNext = r_level - LW'(1);
            default: w_levelNext = r_level;
        endcase
    end

    // RAM write port and registered read port, left unreset so it maps to block RAM.
    always_ff @(posedge inclk) begin
        if (w_push) begin
            r_mem[r_wrPtr] <= i_wrData;
        end
        r_ramQ <= r_mem[w_rdPtrNext];
    end

    // Pointers and fill level; reset discards anything buffered.
    always_ff @(posedge inclk or negedge nReset) begin
        if (!nReset) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_level <= '0;
        end else begin
            if (w_push) begin
                r_wrPtr <= r_wrPtr + AW'(1);
            end
            r_rdPtr <= w_rdPtrNext;
            r_level <= w_levelNext;
        end
    end

    // Head-valid tracking: a word written into an empty FIFO stays hidden for
    // two edges, covering the stale RAM read on its write edge.
    always_ff @(posedge inclk or negedge nReset) begin
        if (!nReset) begin
            r_headFresh <= 1'b0;
            r_headValid <= 1'b0;
        end else begin
            r_headFresh <= w_headNew;
            r_headValid <= (w_levelNext != '0) && !w_headNew
                           && !(r_headFresh && !w_pop);
        end
    end

    assign o_rdData       = r_headValid ? r_ramQ : '0;
    assign o_level        = r_level;
    assign o_levelNext    = w_levelNext;
    assign o_wrDropped    = i_wrReq && w_full && !w_pop;
    assign o_rdWhileEmpty = i_rdReq && w_empty;

endmodule
`default_nettype wire

// File: rtl/fx3_sample_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : fx3_sample_buffer
//  Description : Buffers ADC samples (or a test counter) ahead of the FX3
//                state machine. Presents zero-extended 16-bit words on the
//                GPIF bus, flags a full packet and tracks overflow/underflow.
//  Revision    : 1.0  initial release
// ============================================================================
module fx3_sample_buffer
    import dd_pkg::*;
#(
    parameter int DEPTH        = 16384,
    parameter int PACKET_WORDS = FX3_PACKET_WORDS,
    parameter int SAMPLE_W     = ADC_W
) (
    input  logic                              inclk,
    input  logic                              nReset,
    input  logic [SAMPLE_W-1:0]               adcData,
    input  logic                              adcValid,
    input  logic                              testMode,
    input  logic                              fx3isReading,
    input  logic                              clearFlags,
    output logic [FX3_BUS_W-1:0]              dataOut,
    output logic                              dataAvailable,
    output logic                              bufferOverflow,
    output logic                              bufferUnderflow,
    output logic [fillLevelWidth(DEPTH)-1:0]  fillLevel
);

    localparam int LW = fillLevelWidth(DEPTH);

    logic [SAMPLE_W-1:0] r_testCount;
    logic [SAMPLE_W-1:0] w_wrData;
    logic [SAMPLE_W-1:0] w_fifoData;
    logic [LW-1:0]       w_levelNext;
    logic                w_wrDropped;
    logic                w_rdWhileEmpty;
    logic                r_dataAvailable;
    logic                r_overflow;
    logic                r_underflow;

    // Free-running test counter, stepped by every sample strobe regardless of mode.
    always_ff @(posedge inclk or negedge nReset) begin
        if (!nReset) begin
            r_testCount <= '0;
        end else if (adcValid) begin
            r_testCount <= r_testCount + SAMPLE_W'(1);
        end
    end

    assign w_wrData = testMode ? r_testCount : adcData;

    sync_fifo_fwft #(
        .DEPTH (DEPTH),
        .WIDTH (SAMPLE_W)
    ) u_fifo (
        .inclk          (inclk),
        .nReset         (nReset),
        .i_wrReq        (adcValid),
        .i_wrData       (w_wrData),
        .i_rdReq        (fx3isReading),
        .o_rdData       (w_fifoData),
        .o_level        (fillLevel),
        .o_levelNext    (w_levelNext),
        .o_wrDropped    (w_wrDropped),
        .o_rdWhileEmpty (w_rdWhileEmpty)
    );

    // Packet threshold taken from the next fill level so it tracks fillLevel exactly.
    always_ff @(posedge inclk or negedge nReset) begin
        if (!nReset) begin
            r_dataAvailable <= 1'b0;
        end else begin
            r_dataAvailable <= (w_levelNext >= LW'(PACKET_WORDS));
        end
    end

    // Sticky flags; a set event in the same cycle overrides clearFlags.
    always_ff @(posedge inclk or negedge nReset) begin
        if (!nReset) begin
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (w_wrDropped) begin
                r_overflow <= 1'b1;
            end else if (clearFlags) begin
                r_overflow <= 1'b0;
            end
            if (w_rdWhileEmpty) begin
                r_underflow <= 1'b1;
            end else if (clearFlags) begin
                r_underflow <= 1'b0;
            end
        end
    end

    assign dataOut         = {{(FX3_BUS_W-SAMPLE_W){1'b0}}, w_fifoData};
    assign dataAvailable   = r_dataAvailable;
    assign bufferOverflow  = r_overflow;
    assign bufferUnderflow = r_underflow;

endmodule
`default_nettype wire

// File: tb/tb_fx3_sample_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fx3_sample_buffer
//  Description : Self-checking bench for fx3_sample_buffer: a table of
//                single-cycle vectors plus directed packet, overflow,
//                full-with-read, underflow and streaming sequences.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_fx3_sample_buffer;

    localparam int DEPTH = 16384;
    localparam int PKT   = 8192;
    localparam int NV    = 23;

    logic        inclk        = 1'b0;
    logic        nReset       = 1'b0;
    logic [9:0]  adcData      = '0;
    logic        adcValid     = 1'b0;
    logic        testMode     = 1'b0;
    logic        fx3isReading = 1'b0;
    logic        clearFlags   = 1'b0;
    logic [15:0] dataOut;
    logic        dataAvailable;
    logic        bufferOverflow;
    logic        bufferUnderflow;
    logic [14:0] fillLevel;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        wr;
        logic [9:0]  data;
        logic        tm;
        logic        rd;
        logic        clr;
        logic [15:0] dout;
        logic [14:0] fill;
        logic        avail;
        logic        ovf;
        logic        unf;
    } vec_t;

    vec_t vecs [NV];

    logic [9:0] sb [$];
    logic [9:0] expw;
    int         mism;
    int         firstBad;
    logic [15:0] firstAct;
    logic [15:0] firstExp;
    int         bursts;
    int         burstLeft;
    int         cyc;
    int         popped;
    int         k;

    fx3_sample_buffer #(
        .DEPTH        (DEPTH),
        .PACKET_WORDS (PKT),
        .SAMPLE_W     (10)
    ) dut (
        .inclk           (inclk),
        .nReset          (nReset),
        .adcData         (adcData),
        .adcValid        (adcValid),
        .testMode        (testMode),
        .fx3isReading    (fx3isReading),
        .clearFlags      (clearFlags),
        .dataOut         (dataOut),
        .dataAvailable   (dataAvailable),
        .bufferOverflow  (bufferOverflow),
        .bufferUnderflow (bufferUnderflow),
        .fillLevel       (fillLevel)
    );

    always #5 inclk = ~inclk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge inclk);
        #1;
    endtask

    task automatic idleInputs;
        adcValid     = 1'b0;
        fx3isReading = 1'b0;
        clearFlags   = 1'b0;
    endtask

    task automatic doReset;
        idleInputs();
        testMode = 1'b0;
        nReset   = 1'b0;
        repeat (2) tick();
        nReset = 1'b1;
        tick();
    endtask

    function automatic vec_t mkv(input logic wr, input logic [9:0] data, input logic tm,
                                 input logic rd, input logic clr, input logic [15:0] dout,
                                 input logic [14:0] fill, input logic unf);
        vec_t v;
        v.wr = wr; v.data = data; v.tm = tm; v.rd = rd; v.clr = clr;
        v.dout = dout; v.fill = fill; v.avail = 1'b0; v.ovf = 1'b0; v.unf = unf;
        return v;
    endfunction

    // Watchdog so the run always terminates.
    initial begin
        #5000000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
        $fatal(1, "time limit");
    end

    initial begin
        //            wr    data    tm    rd    clr   dout      fill   unf
        vecs[0]  = mkv(1'b0, 10'h000, 1'b0, 1'b0, 1'b0, 16'h0000, 15'd0, 1'b0);
        vecs[1]  = mkv(1'b0, 10'h000, 1'b0, 1'b1, 1'b0, 16'h0000, 15'd0, 1'b1);
        vecs[2]  = mkv(1'b0, 10'h000, 1'b0, 1'b1, 1'b1, 16'h0000, 15'd0, 1'b1);
        vecs[3]  = mkv(1'b0, 10'h000, 1'b0, 1'b0, 1'b1, 16'h0000, 15'd0, 1'b0);
        vecs[4]  = mkv(1'b1, 10'h3A5, 1'b0, 1'b0, 1'b0, 16'h0000, 15'd1, 1'b0);
        vecs[5]  = mkv(1'b0, 10'h000, 1'b0, 1'b0, 1'b0, 16'h0000, 15'd1, 1'b0);
        vecs[6]  = mkv(1'b0, 10'h000, 1'b0, 1'b0, 1'b0, 16'h03A5, 15'd1, 1'b0);
        vecs[7]  = mkv(1'b1, 10'h155, 1'b0, 1'b0, 1'b0, 16'h03A5, 15'd2, 1'b0);
        vecs[8]  = mkv(1'b1, 10'h2AA, 1'b0, 1'b1, 1'b0, 16'h0155, 15'd2, 1'b0);
        vecs[9]  = mkv(1'b0, 10'h000, 1'b0, 1'b1, 1'b0, 16'h02AA, 15'd1, 1'b0);
        vecs[10] = mkv(1'b0, 10'h000, 1'b0, 1'b1, 1'b0, 16'h0000, 15'd0, 1'b0);
        vecs[11] = mkv(1'b0, 10'h000, 1'b0, 1'b1, 1'b0, 16'h0000, 15'd0, 1'b1);
        vecs[12] = mkv(1'b1, 10'h000, 1'b1, 1'b0, 1'b0, 16'h0000, 15'd1, 1'b1);
        vecs[13] = mkv(1'b0, 10'h000, 1'b0, 1'b0, 1'b0, 16'h0000, 15'd1, 1'b1);
        vecs[14] = mkv(1'b0, 10'h000, 1'b0, 1'b0, 1'b0, 16'h0003, 15'd1, 1'b1);
        vecs[15] = mkv(1'b0, 10'h000, 1'b0, 1'b0, 1'b1, 16'h0003, 15'd1, 1'b0);
        vecs[16] = mkv(1'b1, 10'h3FF, 1'b0, 1'b0, 1'b0, 16'h0003, 15'd2, 1'b0);
        vecs[17] = mkv(1'b0, 10'h000, 1'b0, 1'b1, 1'b0, 16'h03FF, 15'd1, 1'b0);
        vecs[18] = mkv(1'b0, 10'h000, 1'b0, 1'b1, 1'b0, 16'h0000, 15'd0, 1'b0);
        vecs[19] = mkv(1'b1, 10'h000, 1'b1, 1'b1, 1'b0, 16'h0000, 15'd1, 1'b1);
        vecs[20] = mkv(1'b0, 10'h000, 1'b0, 1'b0, 1'b0, 16'h0000, 15'd1, 1'b1);
        vecs[21] = mkv(1'b0, 10'h000, 1'b0, 1'b0, 1'b0, 16'h0005, 15'd1, 1'b1);
        vecs[22] = mkv(1'b0, 10'h000, 1'b0, 1'b1, 1'b1, 16'h0000, 15'd0, 1'b0);

        // ---------------- table vectors from a clean reset ----------------
        doReset();
        for (int i = 0; i < NV; i++) begin
            adcValid     = vecs[i].wr;
            adcData      = vecs[i].data;
            testMode     = vecs[i].tm;
            fx3isReading = vecs[i].rd;
            clearFlags   = vecs[i].clr;
            tick();
            check($sformatf("vec%0d dataOut", i), 32'(dataOut), 32'(vecs[i].dout));
            check($sformatf("vec%0d fillLevel", i), 32'(fillLevel), 32'(vecs[i].fill));
            check($sformatf("vec%0d dataAvailable", i), 32'(dataAvailable), 32'(vecs[i].avail));
            check($sformatf("vec%0d bufferOverflow", i), 32'(bufferOverflow), 32'(vecs[i].ovf));
            check($sformatf("vec%0d bufferUnderflow", i), 32'(bufferUnderflow), 32'(vecs[i].unf));
        end
        idleInputs();
        testMode = 1'b0;

        // ---------------- T1: reset mid-stream ----------------
        fx3isReading = 1'b1;
        tick();
        fx3isReading = 1'b0;
        testMode = 1'b1;
        adcValid = 1'b1;
        repeat (5) tick();
        check("T1 fill before reset", 32'(fillLevel), 32'd5);
        #3;
        nReset = 1'b0;
        #1;
        check("T1 dataOut in reset", 32'(dataOut), 32'd0);
        check("T1 fillLevel in reset", 32'(fillLevel), 32'd0);
        check("T1 dataAvailable in reset", 32'(dataAvailable), 32'd0);
        check("T1 overflow in reset", 32'(bufferOverflow), 32'd0);
        check("T1 underflow in reset", 32'(bufferUnderflow), 32'd0);
        repeat (2) tick();
        adcValid = 1'b0;
        nReset   = 1'b1;
        repeat (3) tick();
        check("T1 fillLevel after release", 32'(fillLevel), 32'd0);
        check("T1 dataOut after release", 32'(dataOut), 32'd0);

        // ---------------- T2: one packet of test counter ----------------
        testMode = 1'b1;
        adcValid = 1'b1;
        for (int i = 0; i < PKT; i++) begin
            tick();
            if (i == PKT - 2) check("T2 dataAvailable one word short", 32'(dataAvailable), 32'd0);
            if (i == PKT - 1) begin
                check("T2 dataAvailable at packet", 32'(dataAvailable), 32'd1);
                check("T2 fillLevel at packet", 32'(fillLevel), 32'(PKT));
            end
        end
        adcValid = 1'b0;
        mism = 0; firstBad = -1; firstAct = '0; firstExp = '0;
        for (int i = 0; i < PKT; i++) begin
            fx3isReading = 1'b1;
            if (dataOut !== 16'(i % 1024)) begin
                if (mism == 0) begin
                    firstBad = i; firstAct = dataOut; firstExp = 16'(i % 1024);
                end
                mism++;
            end
            tick();
            if (i == 0) check("T2 dataAvailable after first read", 32'(dataAvailable), 32'd0);
        end
        fx3isReading = 1'b0;
        check($sformatf("T2 readback mismatches (first idx %0d got %0h want %0h)",
                        firstBad, firstAct, firstExp), 32'(mism), 32'd0);
        check("T2 fillLevel drained", 32'(fillLevel), 32'd0);
        check("T2 overflow clear", 32'(bufferOverflow), 32'd0);
        check("T2 underflow clear", 32'(bufferUnderflow), 32'd0);

        // ---------------- T3: overflow ----------------
        doReset();
        testMode = 1'b1;
        adcValid = 1'b1;
        for (int i = 0; i < DEPTH; i++) tick();
        check("T3 fillLevel full", 32'(fillLevel), 32'(DEPTH));
        check("T3 overflow before excess write", 32'(bufferOverflow), 32'd0);
        for (int i = 0; i < 5; i++) begin
            tick();
            check($sformatf("T3 fillLevel excess write %0d", i), 32'(fillLevel), 32'(DEPTH));
            check($sformatf("T3 overflow excess write %0d", i), 32'(bufferOverflow), 32'd1);
        end
        adcValid   = 1'b0;
        clearFlags = 1'b1;
        tick();
        clearFlags = 1'b0;
        check("T3 overflow cleared", 32'(bufferOverflow), 32'd0);

        // ---------------- T4: full, simultaneous write and read ----------------
        adcValid     = 1'b1;
        fx3isReading = 1'b1;
        tick();
        adcValid     = 1'b0;
        fx3isReading = 1'b0;
        check("T4 fillLevel stays full", 32'(fillLevel), 32'(DEPTH));
        check("T4 no overflow", 32'(bufferOverflow), 32'd0);
        check("T4 head advanced", 32'(dataOut), 32'd1);
        tick();
        check("T4 still no overflow", 32'(bufferOverflow), 32'd0);

        // Readback: words 1..16383 of the first fill, then the word written in T4
        // (test counter after 16384 + 5 strobes = 5). None of the dropped words.
        mism = 0; firstBad = -1; firstAct = '0; firstExp = '0;
        for (int j = 0; j < DEPTH; j++) begin
            fx3isReading = 1'b1;
            if (dataOut !== ((j < DEPTH - 1) ? 16'((j + 1) % 1024) : 16'd5)) begin
                if (mism == 0) begin
                    firstBad = j; firstAct = dataOut;
                    firstExp = (j < DEPTH - 1) ? 16'((j + 1) % 1024) : 16'd5;
                end
                mism++;
            end
            tick();
        end
        fx3isReading = 1'b0;
        check($sformatf("T3 readback mismatches (first idx %0d got %0h want %0h)",
                        firstBad, firstAct, firstExp), 32'(mism), 32'd0);
        check("T3 fillLevel drained", 32'(fillLevel), 32'd0);
        check("T3 no underflow on drain", 32'(bufferUnderflow), 32'd0);

        // ---------------- T5: underflow ----------------
        for (int i = 0; i < 3; i++) begin
            fx3isReading = 1'b1;
            tick();
            check($sformatf("T5 dataOut cycle %0d", i), 32'(dataOut), 32'd0);
            check($sformatf("T5 fillLevel cycle %0d", i), 32'(fillLevel), 32'd0);
            check($sformatf("T5 underflow cycle %0d", i), 32'(bufferUnderflow), 32'd1);
        end
        fx3isReading = 1'b0;
        clearFlags   = 1'b1;
        tick();
        clearFlags = 1'b0;
        check("T5 underflow cleared", 32'(bufferUnderflow), 32'd0);

        // ---------------- T6: streaming with read bursts ----------------
        testMode = 1'b0;
        sb.delete();
        mism = 0; firstBad = -1; firstAct = '0; firstExp = '0;
        bursts = 0; burstLeft = 0; cyc = 0; popped = 0; k = 0;
        while (bursts < 2 && cyc < 40000) begin
            adcValid     = 1'b1;
            adcData      = 10'((k * 37 + 11) & 32'h3FF);
            fx3isReading = (burstLeft > 0);
            if (burstLeft > 0) begin
                if (sb.size() == 0) begin
                    expw = '0;
                    mism++;
                end else begin
                    expw = sb.pop_front();
                    if (dataOut !== {6'b0, expw}) begin
                        if (mism == 0) begin
                            firstBad = popped; firstAct = dataOut; firstExp = {6'b0, expw};
                        end
                        mism++;
                    end
                end
                popped++;
            end
            sb.push_back(adcData);
            k++;
            tick();
            cyc++;
            if (burstLeft > 0) begin
                burstLeft--;
                if (burstLeft == 0) bursts++;
            end else if (dataAvailable) begin
                burstLeft = PKT;
            end
        end
        idleInputs();
        check("T6 bursts completed within budget", 32'(bursts), 32'd2);
        check($sformatf("T6 stream mismatches (first idx %0d got %0h want %0h)",
                        firstBad, firstAct, firstExp), 32'(mism), 32'd0);
        check("T6 words popped", 32'(popped), 32'(2 * PKT));
        check("T6 fillLevel vs scoreboard", 32'(fillLevel), 32'(sb.size()));
        check("T6 no overflow", 32'(bufferOverflow), 32'd0);
        check("T6 no underflow", 32'(bufferUnderflow), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
